// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
//
// Two-port command arbiter in front of a single SDRAM controller. A request
// from port 0 or port 1 is latched, presented to the controller as a held
// read or write strobe until the controller reports busy, acknowledged with
// a one-cycle ack, and (for reads) answered through a shared rdata register
// qualified by a per-port rvalid pulse.
//
// Configuration:
//   SDRAM_ARBITER_FIXED_PRIO_EN  defined   -> port 0 always wins ties,
//                                             no last-grant pointer.
//                                undefined -> round-robin on ties (default).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req0/1, wr0/1            per-port request and command type (1 = write)
//   addr0/1, wdata0/1        per-port address and write data
//   ack0/1                   one-cycle pulse: command taken by controller
//   rvalid0/1, rdata         read data return (rdata shared by both ports)
//   ctl_wr_enable/rd_enable  command strobes to the controller
//   ctl_addr, ctl_wdata      latched command address / write data
//   ctl_busy                 controller executing a command
//   ctl_rd_ready, ctl_rdata  controller read data return
// ---------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  wr0,
    input  logic                  wr1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [BUS_WIDTH-1:0]  wdata0,
    input  logic [BUS_WIDTH-1:0]  wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [BUS_WIDTH-1:0]  rdata,
    output logic                  ctl_wr_enable,
    output logic                  ctl_rd_enable,
    output logic [ADDR_WIDTH-1:0] ctl_addr,
    output logic [BUS_WIDTH-1:0]  ctl_wdata,
    input  logic                  ctl_busy,
    input  logic                  ctl_rd_ready,
    input  logic [BUS_WIDTH-1:0]  ctl_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t state, state_nx;

    // Latched command context: which port won and whether it is a write.
    logic win;      // 0 = port 0, 1 = port 1
    logic wr_lat;

    // Control decodes from the next-state logic.
    logic load;       // IDLE with a request: latch the winner
    logic issue_done; // ISSUE saw ctl_busy: drop enables, ack
    logic rd_cap;     // BUSY read with ctl_rd_ready: capture rdata
    logic release_cmd;// BUSY saw ctl_busy low: command finished

    // Arbitration result for the current cycle.
    logic pick1;
    logic sel_wr;

`ifdef SDRAM_ARBITER_FIXED_PRIO_EN
    // Port 0 always wins a tie.
    always_comb pick1 = req1 & ~req0;
`else
    // Last port granted; resets to port 1 so port 0 takes the first tie.
    logic last_grant;

    // On a tie the port that was not granted last wins.
    always_comb pick1 = req1 & (~req0 | ~last_grant);
`endif

    always_comb sel_wr = pick1 ? wr1 : wr0;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // -----------------------------------------------------------------------
    // Next-state and control decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx    = state;
        load        = 1'b0;
        issue_done  = 1'b0;
        rd_cap      = 1'b0;
        release_cmd = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 | req1) begin
                    load     = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (ctl_busy) begin
                    issue_done = 1'b1;
                    state_nx   = BUSY;
                end
            end
            BUSY: begin
                // Read data returns only matter for a read command; a stray
                // strobe during a write is dropped.
                if (!wr_lat && ctl_rd_ready) rd_cap = 1'b1;
                if (!ctl_busy) begin
                    release_cmd = 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Command latch and controller strobes
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            win           <= 1'b0;
            wr_lat        <= 1'b0;
            ctl_addr      <= '0;
            ctl_wdata     <= '0;
            ctl_wr_enable <= 1'b0;
            ctl_rd_enable <= 1'b0;
        end else if (load) begin
            // Everything is captured here, so later changes on either
            // port's inputs cannot disturb the command in flight.
            win           <= pick1;
            wr_lat        <= sel_wr;
            ctl_addr      <= pick1 ? addr1  : addr0;
            ctl_wdata     <= pick1 ? wdata1 : wdata0;
            ctl_wr_enable <= sel_wr;
            ctl_rd_enable <= ~sel_wr;
        end else if (issue_done) begin
            ctl_wr_enable <= 1'b0;
            ctl_rd_enable <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Handshake pulses and read data return
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata   <= '0;
        end else begin
            ack0    <= issue_done & ~win;
            ack1    <= issue_done &  win;
            rvalid0 <= rd_cap & ~win;
            rvalid1 <= rd_cap &  win;
            if (rd_cap) rdata <= ctl_rdata;
        end
    end

`ifndef SDRAM_ARBITER_FIXED_PRIO_EN
    // Pointer moves only when a command completes; an abandoned command
    // (reset mid-flight) leaves it at its reset value.
    always_ff @(posedge clk) begin
        if (rst)              last_grant <= 1'b1;
        else if (release_cmd) last_grant <= win;
    end
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbiter
//
// Scripted controller model drives ctl_busy / ctl_rd_ready; expected ack and
// rvalid events are queued as stimulus is issued and popped by a monitor as
// the arbiter produces them.
// ---------------------------------------------------------------------------
module tb_sdram_arbiter;

    localparam int BW = 16;
    localparam int AW = 22;

    logic          clk;
    logic          rst;
    logic          req0, req1, wr0, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [BW-1:0] wdata0, wdata1;
    logic          ack0, ack1, rvalid0, rvalid1;
    logic [BW-1:0] rdata;
    logic          ctl_wr_enable, ctl_rd_enable;
    logic [AW-1:0] ctl_addr;
    logic [BW-1:0] ctl_wdata;
    logic          ctl_busy, ctl_rd_ready;
    logic [BW-1:0] ctl_rdata;

    sdram_arbiter #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata),
        .ctl_wr_enable(ctl_wr_enable), .ctl_rd_enable(ctl_rd_enable),
        .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
        .ctl_busy(ctl_busy), .ctl_rd_ready(ctl_rd_ready), .ctl_rdata(ctl_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard of expected handshake events, in order.
    typedef struct {
        bit          rv;    // 0 = ack, 1 = rvalid
        bit          port;
        logic [15:0] data;
    } ev_t;

    ev_t sb[$];

    task automatic push_ack(input bit p);
        ev_t e;
        e.rv = 1'b0; e.port = p; e.data = '0;
        sb.push_back(e);
    endtask

    task automatic push_rv(input bit p, input logic [15:0] d);
        ev_t e;
        e.rv = 1'b1; e.port = p; e.data = d;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ctl_wr_enable & ctl_rd_enable) chk("en_excl", 32'd1, 32'd0);
            if (ack0 | ack1 | rvalid0 | rvalid1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_evt", 32'({rvalid1, rvalid0, ack1, ack0}), 32'd0);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    if (e.rv) begin
                        chk("rvalid_port", 32'({ack1, ack0, rvalid1, rvalid0}), e.port ? 32'd2 : 32'd1);
                        chk("rdata", 32'(rdata), 32'(e.data));
                    end else begin
                        chk("ack_port", 32'({rvalid1, rvalid0, ack1, ack0}), e.port ? 32'd2 : 32'd1);
                    end
                end
            end
        end
    end

    // Controller model for one command. Called with the arbiter already
    // requested; waits for the strobe, raises busy on the second strobe
    // cycle, holds busy for len cycles and optionally returns read data.
    task automatic serve(input int len, input bit do_rd, input logic [15:0] d,
                         input bit drop0, input bit drop1);
        int en_cyc = 0;
        for (int i = 0; i < 20 && !ctl_busy; i++) begin
            @(negedge clk);
            if (ctl_wr_enable | ctl_rd_enable) en_cyc++;
            if (en_cyc == 2) ctl_busy = 1'b1;
        end
        chk("en_cycles", 32'(en_cyc), 32'd2);
        @(negedge clk);
        chk("en_drop", 32'({ctl_wr_enable, ctl_rd_enable}), 32'd0);
        if (drop0) req0 = 1'b0;
        if (drop1) req1 = 1'b0;
        for (int i = 2; i < len; i++) begin
            @(negedge clk);
            ctl_rd_ready = do_rd && (i == 2);
            ctl_rdata    = d;
        end
        @(negedge clk);
        ctl_rd_ready = 1'b0;
        ctl_busy     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        ctl_busy = 0; ctl_rd_ready = 0; ctl_rdata = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ack", 32'({ack1, ack0}), 32'd0);
        chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        chk("rst_en", 32'({ctl_wr_enable, ctl_rd_enable}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_addr", 32'(ctl_addr), 32'd0);
        chk("rst_wdata", 32'(ctl_wdata), 32'd0);
        rst = 1'b0;

        // Single write from port 0
        @(negedge clk);
        req0 = 1; wr0 = 1; addr0 = 22'h00010; wdata0 = 16'hBEEF;
        push_ack(1'b0);
        @(posedge clk); #1;
        chk("wr_lat_en", 32'({ctl_wr_enable, ctl_rd_enable}), 32'd2);
        chk("wr_addr", 32'(ctl_addr), 32'h00010);
        chk("wr_wdata", 32'(ctl_wdata), 32'hBEEF);
        serve(5, 1'b0, 16'h0, 1'b1, 1'b0);

        // Read from port 1, requested right as busy falls: one idle
        // cycle, then the strobe.
        req1 = 1; wr1 = 0; addr1 = 22'h3FFFFF;
        push_ack(1'b1);
        push_rv(1'b1, 16'h1234);
        @(posedge clk); #1;
        chk("turnaround_idle", 32'({ctl_wr_enable, ctl_rd_enable}), 32'd0);
        @(posedge clk); #1;
        chk("rd_lat_en", 32'({ctl_wr_enable, ctl_rd_enable}), 32'd1);
        chk("rd_addr", 32'(ctl_addr), 32'h3FFFFF);
        serve(5, 1'b1, 16'h1234, 1'b0, 1'b1);
        @(negedge clk);
        chk("rd_hold", 32'(rdata), 32'h1234);

        // Stray strobe in IDLE
        ctl_rd_ready = 1; ctl_rdata = 16'hDEAD;
        @(negedge clk);
        ctl_rd_ready = 0;
        @(negedge clk);
        chk("stray_idle", 32'(rdata), 32'h1234);

        // Stray strobe during a write's BUSY; port 1 changes meanwhile
        req0 = 1; wr0 = 1; addr0 = 22'h00155; wdata0 = 16'hA5A5;
        push_ack(1'b0);
        @(posedge clk); #1;
        addr1 = 22'h00077;
        serve(4, 1'b1, 16'hDEAD, 1'b1, 1'b0);
        chk("stray_wr_addr", 32'(ctl_addr), 32'h00155);
        @(negedge clk);
        chk("stray_wr_rdata", 32'(rdata), 32'h1234);

        // Reset in the middle of a read
        req1 = 1; wr1 = 0; addr1 = 22'h2AAAA;
        push_ack(1'b1);
        @(posedge clk); #1;
        chk("rr_lat_en", 32'({ctl_wr_enable, ctl_rd_enable}), 32'd1);
        @(negedge clk);
        ctl_busy = 1;
        @(negedge clk);
        req1 = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        ctl_rd_ready = 1; ctl_rdata = 16'h7777;
        @(negedge clk);
        ctl_rd_ready = 0; ctl_busy = 0;
        repeat (3) @(negedge clk);
        chk("rr_en", 32'({ctl_wr_enable, ctl_rd_enable}), 32'd0);
        chk("rr_rdata", 32'(rdata), 32'd0);
        chk("rr_addr", 32'(ctl_addr), 32'd0);

        // Contention: both ports held high for four commands
        req0 = 1; wr0 = 1; addr0 = 22'h00001; wdata0 = 16'h1111;
        req1 = 1; wr1 = 1; addr1 = 22'h00002; wdata1 = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            bit exp_p;
`ifdef SDRAM_ARBITER_FIXED_PRIO_EN
            exp_p = 1'b0;
`else
            exp_p = k[0];
`endif
            push_ack(exp_p);
            serve(3, 1'b0, 16'h0, k == 3, k == 3);
            chk("cont_addr", 32'(ctl_addr), exp_p ? 32'd2 : 32'd1);
        end
        repeat (4) @(negedge clk);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
